// File: rtl/ls1u_bus_pkg.sv
// Shared types and constants for the LS1u core memory responder.
package ls1u_bus_pkg;

  localparam int unsigned TAG_W  = 24;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  // Instruction class field value marking a data load
  localparam logic [4:0] FUNCT5_LOAD = 5'h04;

  // External memory read latency in cycles (strobe to data)
  localparam int unsigned MEM_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_F_LO,
    ST_F_HI,
    ST_F_END,
    ST_L_RD,
    ST_L_CAP
  } state_e;

  // True when the instruction word requests a data load
  function automatic logic is_load_op(input logic [WORD_W-1:0] w);
    return w[15:11] == FUNCT5_LOAD;
  endfunction

endpackage

// File: rtl/ls1u_mem_responder.sv
// LS1u bus responder: one-word fetch register, one-byte load register and a
// one-entry store buffer in front of a single-port 8-bit synchronous memory.
module ls1u_mem_responder
  import ls1u_bus_pkg::*;
#(
  parameter int unsigned    AW    = 20,
  parameter logic [AW-1:0]  IBASE = '0,
  parameter logic [AW-1:0]  DBASE = AW'(32'h0008_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  iaddr,
  output logic [WORD_W-1:0] instr,
  input  logic [TAG_W-1:0]  daddr,
  output logic [BYTE_W-1:0] ddata_i,
  input  logic [BYTE_W-1:0] ddata_o,
  input  logic              dwrite,
  output logic              WAIT,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    itag_q, itag_d;
  logic [WORD_W-1:0]   iword_q, iword_d;
  logic                ivalid_q, ivalid_d;
  logic [TAG_W-1:0]    ltag_q, ltag_d;
  logic [BYTE_W-1:0]   lbyte_q, lbyte_d;
  logic                lvalid_q, lvalid_d;
  logic [TAG_W-1:0]    waddr_q, waddr_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                wfull_q, wfull_d;

  logic                ihit, lhit, is_load, wait_c, wr_hits_iword;
  logic [AW-1:0]       i_lo_addr, i_hi_addr, l_addr, w_addr;

  // Hit detection, stall request and byte addresses (all wrap modulo 2^AW)
  assign ihit          = ivalid_q && (itag_q == iaddr);
  assign lhit          = lvalid_q && (ltag_q == daddr);
  assign is_load       = ihit && is_load_op(iword_q);
  assign wait_c        = !ihit || dwrite || wfull_q || (is_load && !lhit);
  assign i_lo_addr     = IBASE + AW'({itag_q, 1'b0});
  assign i_hi_addr     = i_lo_addr + AW'(1);
  assign l_addr        = DBASE + AW'(ltag_q);
  assign w_addr        = DBASE + AW'(waddr_q);
  assign wr_hits_iword = (w_addr == i_lo_addr) || (w_addr == i_hi_addr);

  // Next-state logic for the sequencer and the fetch/load/store registers
  always_comb begin
    state_d  = state_q;
    itag_d   = itag_q;
    iword_d  = iword_q;
    ivalid_d = ivalid_q;
    ltag_d   = ltag_q;
    lbyte_d  = lbyte_q;
    lvalid_d = lvalid_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wfull_d  = wfull_q;

    // A store arriving while the buffer is occupied is dropped
    if (dwrite && !wfull_q) begin
      waddr_d = daddr;
      wdata_d = ddata_o;
      wfull_d = 1'b1;
    end

    // Each completed load consumes its byte so the next one re-reads memory
    if (is_load && lhit && !wait_c) begin
      lvalid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wfull_q) begin
          state_d = ST_WR;
        end else if (!ihit) begin
          itag_d   = iaddr;
          ivalid_d = 1'b0;
          state_d  = ST_F_LO;
        end else if (is_load && !lhit) begin
          ltag_d   = daddr;
          lvalid_d = 1'b0;
          state_d  = ST_L_RD;
        end
      end
      ST_WR: begin
        wfull_d = 1'b0;
        if (wr_hits_iword) ivalid_d = 1'b0;
        if (waddr_q == ltag_q) lvalid_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_F_LO:  state_d = ST_F_HI;
      ST_F_HI: begin
        iword_d[7:0] = mem_rdata;
        state_d      = ST_F_END;
      end
      ST_F_END: begin
        iword_d[15:8] = mem_rdata;
        ivalid_d      = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_L_RD:  state_d = ST_L_CAP;
      ST_L_CAP: begin
        lbyte_d  = mem_rdata;
        lvalid_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory strobes and core-facing outputs, forced quiet while in reset
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      ST_WR:    begin mem_we = 1'b1; mem_addr = w_addr;    end
      ST_F_LO:  begin mem_re = 1'b1; mem_addr = i_lo_addr; end
      ST_F_HI:  begin mem_re = 1'b1; mem_addr = i_hi_addr; end
      ST_L_RD:  begin mem_re = 1'b1; mem_addr = l_addr;    end
      default:  ;
    endcase
    if (!rst) begin
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
    end
    mem_wdata = wdata_q;
    instr     = (rst && ihit) ? iword_q : '0;
    ddata_i   = rst ? lbyte_q : '0;
    WAIT      = !rst || wait_c;
  end

  // State and register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      itag_q   <= '0;
      iword_q  <= '0;
      ivalid_q <= 1'b0;
      ltag_q   <= '0;
      lbyte_q  <= '0;
      lvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wfull_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      itag_q   <= itag_d;
      iword_q  <= iword_d;
      ivalid_q <= ivalid_d;
      ltag_q   <= ltag_d;
      lbyte_q  <= lbyte_d;
      lvalid_q <= lvalid_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wfull_q  <= wfull_d;
    end
  end

endmodule

// File: tb/tb_ls1u_mem_responder.sv
// Self-checking bench for ls1u_mem_responder: directed latency/coherence/reset
// steps followed by randomized fetch/load/store traffic against a byte-array model.
module tb_ls1u_mem_responder;

  localparam logic [19:0] IBASE = 20'h00000;
  localparam logic [19:0] DBASE = 20'h80000;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] iaddr, daddr;
  logic [15:0] instr;
  logic [7:0]  ddata_i, ddata_o;
  logic        dwrite, WAIT;
  logic [19:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  // Emulated external memory and the architectural reference image
  logic [7:0]  phys_mem [0:1048575];
  logic [7:0]  ref_mem  [0:1048575];
  logic        ld_en = 1'b0;
  logic [19:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  int          we_count = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ls1u_mem_responder dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .instr(instr), .daddr(daddr),
    .ddata_i(ddata_i), .ddata_o(ddata_o), .dwrite(dwrite), .WAIT(WAIT),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory, read data one cycle after the strobe
  always @(posedge clk) begin
    if (ld_en) phys_mem[ld_addr] <= ld_data;
    if (mem_we) begin
      phys_mem[mem_addr] <= mem_wdata;
      we_count <= we_count + 1;
    end
    if (mem_re) mem_rdata <= phys_mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [23:0] a);
    logic [19:0] b;
    b = IBASE + 20'({a, 1'b0});
    return {ref_mem[b + 20'd1], ref_mem[b]};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    return ref_mem[DBASE + 20'(a)];
  endfunction

  function automatic logic word_is_load(input logic [15:0] w);
    return w[15:11] == 5'h04;
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic load_byte(input logic [19:0] a, input logic [7:0] d);
    cyc;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    ref_mem[a] = d;
  endtask

  task automatic load_word(input int n, input logic [15:0] w);
    load_byte(IBASE + 20'(2 * n), w[7:0]);
    load_byte(IBASE + 20'(2 * n + 1), w[15:8]);
  endtask

  // Bounded wait for the core to be released
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    smp;
    while (WAIT !== 1'b0 && n < 40) begin
      smp;
      n++;
    end
    chk({tag, "_ready"}, 32'(WAIT), 32'(0));
  endtask

  // Wait for release, then compare against the reference image
  task automatic check_ready(input string tag);
    logic [15:0] w;
    wait_ready(tag);
    w = ref_word(iaddr);
    chk({tag, "_instr"}, 32'(instr), 32'(w));
    if (word_is_load(w)) chk({tag, "_ddata"}, 32'(ddata_i), 32'(ref_byte(daddr)));
  endtask

  // Cycle-exact fetch miss: NOP and IDLE first, lo/hi reads, then the word
  task automatic fetch_check(input string tag, input logic [23:0] a, input logic [15:0] w,
                             input logic ld);
    cyc;
    iaddr = a;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk({tag, "_wait"}, 32'(WAIT), 32'(1));
      if (k == 0) begin
        chk({tag, "_nop"}, 32'(instr), 32'(0));
        chk({tag, "_idle_re"}, 32'(mem_re), 32'(0));
      end
      if (k == 1) begin
        chk({tag, "_lo_re"}, 32'(mem_re), 32'(1));
        chk({tag, "_lo_addr"}, 32'(mem_addr), 32'(IBASE + 20'(2 * a)));
      end
      if (k == 2) chk({tag, "_hi_addr"}, 32'(mem_addr), 32'(IBASE + 20'(2 * a + 1)));
      cyc;
    end
    smp;
    chk({tag, "_instr"}, 32'(instr), 32'(w));
    if (!ld) chk({tag, "_done"}, 32'(WAIT), 32'(0));
  endtask

  initial begin
    logic [15:0] w;
    logic [23:0] na, sa;
    logic [19:0] bb;
    logic [7:0]  sd;
    int          op, guard, we_before;

    rst = 1'b0; iaddr = '0; daddr = '0; ddata_o = '0; dwrite = 1'b0;

    // Preload memory while held in reset
    load_word(0, 16'h1234);
    load_word(1, 16'h3000);
    load_word(2, 16'h2100);
    load_word(3, 16'h4321);
    for (int n = 4; n < 8; n++) load_word(n, 16'h0000);
    for (int n = 8; n < 64; n++) begin
      w = 16'($urandom);
      w[15:11] = (n % 2 == 0) ? 5'h04 : 5'($urandom_range(5, 31));
      load_word(n, w);
    end
    load_byte(DBASE + 20'h10, 8'hA5);
    load_byte(DBASE + 20'h20, 8'h3C);
    load_byte(DBASE + 20'h30, 8'h00);
    for (int i = 0; i < 16; i++) load_byte(DBASE + 20'h40 + 20'(i), 8'($urandom));
    cyc;
    ld_en = 1'b0;

    // Outputs while in reset
    smp;
    chk("rst_wait", 32'(WAIT), 32'(1));
    chk("rst_re", 32'(mem_re), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_instr", 32'(instr), 32'(0));
    chk("rst_ddata", 32'(ddata_i), 32'(0));

    // Reset release with iaddr=0: four WAIT cycles then 16'h1234
    cyc;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk("t1_wait", 32'(WAIT), 32'(1));
      if (k == 1) chk("t1_lo_addr", 32'(mem_addr), 32'(0));
      if (k == 2) chk("t1_hi_addr", 32'(mem_addr), 32'(1));
      cyc;
    end
    smp;
    chk("t1_instr", 32'(instr), 32'(16'h1234));
    chk("t1_done", 32'(WAIT), 32'(0));

    // New miss on word 1
    fetch_check("t2", 24'd1, 16'h3000, 1'b0);

    // Load instruction, three WAIT cycles, byte delivered, then re-read
    daddr = 24'h000010;
    fetch_check("t3", 24'd2, 16'h2100, 1'b1);
    chk("t3_lmiss", 32'(WAIT), 32'(1));
    cyc; smp;
    chk("t3_lrd_re", 32'(mem_re), 32'(1));
    chk("t3_lrd_addr", 32'(mem_addr), 32'(DBASE + 20'h10));
    chk("t3_lrd_wait", 32'(WAIT), 32'(1));
    cyc; smp;
    chk("t3_lcap_wait", 32'(WAIT), 32'(1));
    cyc; smp;
    chk("t3_lhit_wait", 32'(WAIT), 32'(0));
    chk("t3_ddata", 32'(ddata_i), 32'(8'hA5));
    cyc; smp;
    chk("t3_retired", 32'(WAIT), 32'(1));
    cyc; smp;
    chk("t3_reread", 32'(mem_re), 32'(1));

    // Store then load of the same byte: write drains before the read
    cyc;
    iaddr = 24'd1;
    check_ready("t4_fetch");
    cyc;
    dwrite = 1'b1; daddr = 24'h10; ddata_o = 8'h5A;
    ref_mem[DBASE + 20'h10] = 8'h5A;
    smp;
    chk("t4_dw_wait", 32'(WAIT), 32'(1));
    cyc;
    dwrite = 1'b0; iaddr = 24'd2;
    smp;
    chk("t4_idle_we", 32'(mem_we), 32'(0));
    chk("t4_idle_re", 32'(mem_re), 32'(0));
    chk("t4_idle_wait", 32'(WAIT), 32'(1));
    cyc; smp;
    chk("t4_wr_we", 32'(mem_we), 32'(1));
    chk("t4_wr_addr", 32'(mem_addr), 32'(20'h80010));
    chk("t4_wr_data", 32'(mem_wdata), 32'(8'h5A));
    check_ready("t4_load");
    chk("t4_ddata", 32'(ddata_i), 32'(8'h5A));

    // Store aliasing the low byte of the fetched word forces a refetch
    cyc;
    iaddr = 24'd1;
    check_ready("t5_fetch");
    cyc;
    dwrite = 1'b1; daddr = 24'h080002; ddata_o = 8'h77;
    ref_mem[20'h00002] = 8'h77;
    smp;
    chk("t5_dw_wait", 32'(WAIT), 32'(1));
    cyc;
    dwrite = 1'b0; daddr = 24'h40;
    smp;
    cyc; smp;
    chk("t5_wr_we", 32'(mem_we), 32'(1));
    chk("t5_wr_addr", 32'(mem_addr), 32'(20'h00002));
    cyc; smp;
    chk("t5_inval_wait", 32'(WAIT), 32'(1));
    chk("t5_inval_instr", 32'(instr), 32'(0));
    cyc; smp;
    chk("t5_refetch_re", 32'(mem_re), 32'(1));
    chk("t5_refetch_addr", 32'(mem_addr), 32'(2));
    check_ready("t5_new");
    chk("t5_instr", 32'(instr), 32'(16'h3077));

    // Non-aliasing store leaves the fetched word valid
    cyc;
    dwrite = 1'b1; daddr = 24'h20; ddata_o = 8'h11;
    ref_mem[DBASE + 20'h20] = 8'h11;
    cyc;
    dwrite = 1'b0; daddr = 24'h40;
    smp;
    cyc; smp;
    chk("t5b_wr_addr", 32'(mem_addr), 32'(20'h80020));
    cyc; smp;
    chk("t5b_wait", 32'(WAIT), 32'(0));
    chk("t5b_instr", 32'(instr), 32'(16'h3077));

    // Reset in the middle of a fetch
    cyc;
    iaddr = 24'd3;
    smp; cyc; smp;
    chk("t6_flo", 32'(mem_re), 32'(1));
    cyc;
    rst = 1'b0;
    smp;
    chk("t6_rst_re", 32'(mem_re), 32'(0));
    chk("t6_rst_wait", 32'(WAIT), 32'(1));
    cyc;
    rst = 1'b1;
    smp;
    chk("t6_idle_re", 32'(mem_re), 32'(0));
    chk("t6_idle_we", 32'(mem_we), 32'(0));
    chk("t6_idle_wait", 32'(WAIT), 32'(1));
    chk("t6_idle_instr", 32'(instr), 32'(0));
    cyc; smp;
    chk("t6_restart_re", 32'(mem_re), 32'(1));
    chk("t6_restart_addr", 32'(mem_addr), 32'(6));
    check_ready("t6_fetch");
    chk("t6_instr", 32'(instr), 32'(16'h4321));

    // Reset with a buffered store: the store is lost
    we_before = we_count;
    cyc;
    dwrite = 1'b1; daddr = 24'h30; ddata_o = 8'hEE;
    cyc;
    dwrite = 1'b0; rst = 1'b0;
    smp;
    chk("t6w_rst_we", 32'(mem_we), 32'(0));
    cyc;
    rst = 1'b1;
    smp;
    chk("t6w_idle_we", 32'(mem_we), 32'(0));
    chk("t6w_idle_wait", 32'(WAIT), 32'(1));
    check_ready("t6w_fetch");
    chk("t6w_no_write", 32'(we_count - we_before), 32'(0));
    chk("t6w_mem", 32'(phys_mem[DBASE + 20'h30]), 32'(ref_mem[DBASE + 20'h30]));

    // Randomized traffic against the reference image
    daddr = 24'h40;
    for (int it = 0; it < 120; it++) begin
      op = int'($urandom_range(0, 2));
      w = ref_word(iaddr);
      if (op == 1 && !word_is_load(w)) begin
        if ($urandom_range(0, 3) == 0) begin
          bb = IBASE + 20'({iaddr, 1'b0}) + 20'($urandom_range(0, 1));
          sa = 24'(bb - DBASE);
        end else begin
          sa = 24'h40 + 24'($urandom_range(0, 15));
        end
        sd = 8'($urandom);
        cyc;
        dwrite = 1'b1; daddr = sa; ddata_o = sd;
        ref_mem[DBASE + 20'(sa)] = sd;
        cyc;
        dwrite = 1'b0; daddr = 24'h40 + 24'($urandom_range(0, 15));
        check_ready("rnd_store");
      end else begin
        na = iaddr;
        guard = 0;
        while (na == iaddr && guard < 100) begin
          na = 24'($urandom_range(8, 63));
          if (op == 2) na[0] = 1'b0;
          guard++;
        end
        cyc;
        iaddr = na;
        daddr = 24'h40 + 24'($urandom_range(0, 15));
        check_ready("rnd_fetch");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
